// File: rtl/cfo_pkg.sv
// cfo_pkg: shared width default, FSM encoding and phase type for the CFO control path.
package cfo_pkg;
   localparam int PHASE_WIDTH = 24;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_TRACK   = 2'd1;
   localparam logic [1:0] ST_FILTER  = 2'd2;
   localparam logic [1:0] ST_PENDING = 2'd3;
   typedef logic signed [PHASE_WIDTH-1:0] phase_t;
endpackage

// File: rtl/cfo_iir_step.sv
// cfo_iir_step: one first-order IIR update acc + ((est - acc) >>> shift), bypassed on the first sample.
module cfo_iir_step import cfo_pkg::*; #(
   parameter int W  = PHASE_WIDTH,
   parameter int SW = 4
) (
   input  logic signed [W-1:0]  acc_i,
   input  logic signed [W-1:0]  est_i,
   input  logic                 acc_valid_i,
   input  logic [SW-1:0]        shift_i,
   output logic signed [W-1:0]  acc_o
);
   logic signed [W:0] diff, step, sum;
   // One guard bit keeps est - acc exact; the sum always lands between acc and est.
   always_comb begin
      diff  = (W+1)'(est_i) - (W+1)'(acc_i);
      step  = diff >>> shift_i;
      sum   = (W+1)'(acc_i) + step;
      acc_o = (!acc_valid_i || shift_i == '0) ? est_i : sum[W-1:0];
   end
endmodule

// File: rtl/cfo_ctrl.sv
// cfo_ctrl: filters CFO estimates and commits phase_cfo to cfo_corr only at packet boundaries.
module cfo_ctrl #(
   parameter int PHASE_WIDTH = cfo_pkg::PHASE_WIDTH,
   parameter int SHIFT_WIDTH = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run_rx,
   input  logic                          est_tvalid,
   output logic                          est_tready,
   input  logic signed [PHASE_WIDTH-1:0] est_tdata,
   input  logic                          in_tvalid,
   input  logic                          in_tready,
   input  logic                          in_tlast,
   input  logic [SHIFT_WIDTH-1:0]        cfg_alpha_shift,
   input  logic                          cfg_manual_en,
   input  logic signed [PHASE_WIDTH-1:0] cfg_manual_phase,
   output logic signed [PHASE_WIDTH-1:0] phase_cfo,
   output logic                          pending,
   output logic [CNT_WIDTH-1:0]          upd_cnt
);
   import cfo_pkg::*;
   logic [1:0] state_q, state_d;
   logic signed [PHASE_WIDTH-1:0] est_q, acc_q, phase_q, man_phase_q, acc_nxt;
   logic acc_valid_q, in_pkt_q, man_en_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic beat, est_beat, bnd, man_chg, commit;

   cfo_iir_step #(.W(PHASE_WIDTH), .SW(SHIFT_WIDTH)) u_iir (
      .acc_i       (acc_q),
      .est_i       (est_q),
      .acc_valid_i (acc_valid_q),
      .shift_i     (cfg_alpha_shift),
      .acc_o       (acc_nxt)
   );

   assign est_tready = run_rx && state_q == ST_TRACK;
   assign pending    = state_q == ST_PENDING;
   assign phase_cfo  = phase_q;
   assign upd_cnt    = cnt_q;

   always_comb begin
      beat     = in_tvalid & in_tready;
      est_beat = est_tvalid & est_tready;
      bnd      = !in_pkt_q || (beat && in_tlast);
      man_chg  = cfg_manual_en != man_en_q || cfg_manual_phase != man_phase_q;
      commit   = run_rx && state_q == ST_PENDING && bnd;
      state_d  = !run_rx                  ? ST_IDLE :
                 state_q == ST_IDLE       ? ST_TRACK :
                 state_q == ST_TRACK      ? (est_beat ? ST_FILTER : man_chg ? ST_PENDING : ST_TRACK) :
                 state_q == ST_FILTER     ? ST_PENDING :
                 bnd                      ? ST_TRACK : ST_PENDING;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         est_q       <= '0;
         acc_q       <= '0;
         acc_valid_q <= 1'b0;
         in_pkt_q    <= 1'b0;
         phase_q     <= '0;
         cnt_q       <= '0;
         man_en_q    <= 1'b0;
         man_phase_q <= '0;
      end else begin
         state_q     <= state_d;
         in_pkt_q    <= beat ? !in_tlast : in_pkt_q;
         man_en_q    <= cfg_manual_en;
         man_phase_q <= cfg_manual_phase;
         if (est_beat) est_q <= est_tdata;
         if (run_rx && state_q == ST_FILTER) begin
            acc_q       <= acc_nxt;
            acc_valid_q <= 1'b1;
         end
         if (commit) begin
            phase_q <= cfg_manual_en ? cfg_manual_phase : acc_q;
            cnt_q   <= cnt_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cfo_ctrl.sv
// tb_cfo_ctrl: directed vector table plus hand-written packet, manual, run_rx and reset sequences.
module tb_cfo_ctrl;
   logic clk = 1'b0;
   logic reset, run_rx, est_tvalid, est_tready, in_tvalid, in_tready, in_tlast;
   logic signed [23:0] est_tdata, man_phase, phase_cfo;
   logic [3:0] alpha;
   logic man_en, pending;
   logic [15:0] upd_cnt;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic run, ev;
      logic signed [23:0] ed;
      logic signed [23:0] ph;
      logic pend, rdy;
      logic [15:0] cnt;
   } vec_t;
   vec_t tbl [10];

   cfo_ctrl dut (
      .clk(clk), .reset(reset), .run_rx(run_rx),
      .est_tvalid(est_tvalid), .est_tready(est_tready), .est_tdata(est_tdata),
      .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
      .cfg_alpha_shift(alpha), .cfg_manual_en(man_en), .cfg_manual_phase(man_phase),
      .phase_cfo(phase_cfo), .pending(pending), .upd_cnt(upd_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic iv, input logic il, input logic ev, input logic signed [23:0] ed);
      in_tvalid  = iv;
      in_tready  = 1'b1;
      in_tlast   = il;
      est_tvalid = ev;
      est_tdata  = ed;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{1, 0,      0,    0, 0, 1, 0};
      tbl[1] = '{1, 1,   8192,    0, 0, 0, 0};
      tbl[2] = '{1, 0,      0,    0, 1, 0, 0};
      tbl[3] = '{1, 0,      0, 8192, 0, 1, 1};
      tbl[4] = '{1, 1,      0, 8192, 0, 0, 1};
      tbl[5] = '{1, 0,      0, 8192, 1, 0, 1};
      tbl[6] = '{1, 0,      0, 6144, 0, 1, 2};
      tbl[7] = '{1, 1,  -8192, 6144, 0, 0, 2};
      tbl[8] = '{1, 0,      0, 6144, 1, 0, 2};
      tbl[9] = '{1, 0,      0, 2560, 0, 1, 3};
      reset = 1'b1; run_rx = 1'b0; alpha = 4'd2; man_en = 1'b0; man_phase = '0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("rst_phase", phase_cfo, 0);
      chk("rst_cnt", upd_cnt, 0);
      chk("rst_pending", pending, 0);
      chk("rst_tready", est_tready, 0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         run_rx = tbl[i].run;
         step(0, 0, tbl[i].ev, tbl[i].ed);
         chk($sformatf("row%0d_phase", i), phase_cfo, tbl[i].ph);
         chk($sformatf("row%0d_pending", i), pending, tbl[i].pend);
         chk($sformatf("row%0d_tready", i), est_tready, tbl[i].rdy);
         chk($sformatf("row%0d_cnt", i), upd_cnt, tbl[i].cnt);
      end
      // 100-beat packet; estimate at beat 10, second estimate held from beat 12
      for (int i = 0; i < 100; i++) begin
         step(1, i == 99, i == 10 || i >= 12, i == 10 ? 24'sd4096 : 24'sd1000);
         if (i == 50) begin
            chk("pkt_hold_phase", phase_cfo, 2560);
            chk("pkt_hold_pending", pending, 1);
            chk("pkt_hold_tready", est_tready, 0);
            chk("pkt_hold_cnt", upd_cnt, 3);
         end
      end
      chk("pkt_tlast_phase", phase_cfo, 2944);
      chk("pkt_tlast_cnt", upd_cnt, 4);
      chk("pkt_tlast_tready", est_tready, 1);
      step(1, 0, 1, 1000);
      step(1, 0, 0, 0);
      chk("held_est_pending", pending, 1);
      chk("held_est_phase", phase_cfo, 2944);
      step(1, 1, 0, 0);
      chk("held_est_phase2", phase_cfo, 2458);
      chk("held_est_cnt", upd_cnt, 5);
      // manual override set mid-packet
      step(1, 0, 0, 0);
      man_en = 1'b1; man_phase = -24'sd1000;
      step(1, 0, 0, 0);
      chk("man_pending", pending, 1);
      chk("man_hold_phase", phase_cfo, 2458);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      chk("man_phase", phase_cfo, -1000);
      chk("man_cnt", upd_cnt, 6);
      man_en = 1'b0;
      step(0, 0, 0, 0);
      chk("man_off_pending", pending, 1);
      step(0, 0, 0, 0);
      chk("man_off_phase", phase_cfo, 2458);
      chk("man_off_cnt", upd_cnt, 7);
      // run_rx drop before the boundary
      step(1, 0, 0, 0);
      step(1, 0, 1, 5000);
      step(1, 0, 0, 0);
      chk("drop_pre_pending", pending, 1);
      run_rx = 1'b0;
      step(1, 0, 0, 0);
      chk("drop_pending", pending, 0);
      chk("drop_tready", est_tready, 0);
      chk("drop_phase", phase_cfo, 2458);
      chk("drop_cnt", upd_cnt, 7);
      step(1, 1, 0, 0);
      chk("drop_tlast_phase", phase_cfo, 2458);
      run_rx = 1'b1;
      step(0, 0, 0, 0);
      chk("drop_resume_tready", est_tready, 1);
      // reset while pending
      step(1, 0, 1, 7000);
      step(1, 0, 0, 0);
      chk("rstp_pending", pending, 1);
      reset = 1'b1; man_phase = '0;
      step(0, 0, 0, 0);
      chk("rstp_phase", phase_cfo, 0);
      chk("rstp_cnt", upd_cnt, 0);
      chk("rstp_pending0", pending, 0);
      reset = 1'b0; alpha = 4'd3;
      step(0, 0, 0, 0);
      step(0, 0, 1, 300);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("rstp_first_phase", phase_cfo, 300);
      chk("rstp_first_cnt", upd_cnt, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cfo_ctrl.md
Name: cfo_ctrl

Overview:
Controller that sequences the phase_cfo input of cfo_corr.
- Accepts signed CFO phase-increment estimates from an estimator over a valid/ready stream.
- Smooths each estimate with a first-order IIR (shift-based alpha).
- Commits the new phase_cfo only at packet boundaries, by snooping the cfo_corr input handshake, so the correction never changes mid-packet.
- Sits between the CFO estimator, the control registers and cfo_corr in the RX chain.

Parameters:
PHASE_WIDTH, 24, width of estimate, filter state and phase_cfo (two's complement).
SHIFT_WIDTH, 4, width of cfg_alpha_shift.
CNT_WIDTH, 16, width of the update counter.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
run_rx  in  1  RX enable; low forces IDLE.
est_tvalid  in  1  estimate valid.
est_tready  out  1  estimate ready.
est_tdata  in  PHASE_WIDTH  signed phase-increment estimate.
in_tvalid  in  1  snoop of cfo_corr input valid.
in_tready  in  1  snoop of cfo_corr input ready.
in_tlast  in  1  snoop of cfo_corr input last.
cfg_alpha_shift  in  SHIFT_WIDTH  IIR shift; 0 = no smoothing.
cfg_manual_en  in  1  override filter output with cfg_manual_phase.
cfg_manual_phase  in  PHASE_WIDTH  manual phase increment.
phase_cfo  out  PHASE_WIDTH  phase increment driven to cfo_corr.
pending  out  1  filtered value waiting for a boundary.
upd_cnt  out  CNT_WIDTH  number of commits to phase_cfo; wraps.

Behaviour:
- Handshakes: est beat = est_tvalid & est_tready. Data beat = in_tvalid & in_tready.
- Reset values:
  - phase_cfo = 0, upd_cnt = 0, pending = 0, est_tready = 0.
  - Filter accumulator acc = 0, acc_valid = 0, in_pkt = 0, state = IDLE.
- in_pkt tracking:
  - Set on a data beat with in_tlast = 0.
  - Cleared on a data beat with in_tlast = 1.
  - Tracked in every state.
- Boundary condition (checked on a clock edge): in_pkt == 0, or a data beat with in_tlast = 1 occurs on that edge.
- State machine:
  - IDLE: est_tready = 0. Go to TRACK when run_rx = 1.
  - TRACK: est_tready = 1. On an est beat, latch est_tdata and go to FILTER.
  - FILTER (1 cycle):
    - If acc_valid = 0 or cfg_alpha_shift = 0: acc <= est.
    - Otherwise: acc <= acc + ((est - acc) >>> cfg_alpha_shift).
    - Subtraction uses PHASE_WIDTH+1 bits with an arithmetic shift. The result always lies between acc and est, so it cannot overflow and needs no saturation.
    - Set acc_valid = 1 and go to PENDING.
  - PENDING:
    - pending = 1 and est_tready = 0; the estimator is back-pressured and estimates are never dropped.
    - On the first edge meeting the boundary condition: commit, upd_cnt++, go to TRACK.
- Commit value: cfg_manual_en ? cfg_manual_phase : acc.
- Latency: est beat at edge N → acc at edge N+1 → earliest commit at edge N+2 (when idle between packets). Otherwise the commit lands on the tlast-beat edge, so the next packet's first sample already uses the new phase_cfo.
- Manual mode:
  - A change of cfg_manual_en or cfg_manual_phase while in TRACK triggers an immediate move to PENDING, with no estimate consumed.
  - The filter keeps running in manual mode.
- run_rx falling (any state):
  - Next state is IDLE and pending is cleared; an uncommitted value is discarded.
  - phase_cfo, acc and acc_valid are held.
- Reset in any state returns every register to its reset value on the same edge. Reset has priority over run_rx and all handshakes.
- phase_cfo changes only on a commit edge or on reset.

Decomposition:
- Shared package cfo_pkg:
  - PHASE_WIDTH default.
  - State encoding (IDLE, TRACK, FILTER, PENDING).
  - Signed phase typedef.
- One sub-module, cfo_iir_step: combinational acc + ((est - acc) >>> shift) with the first-sample bypass. Reused by future CFO tracking loops.
- The FSM, packet tracker and commit logic stay in cfo_ctrl.

Test Plan:
1. Idle commit: run_rx = 1, no packets, alpha = 2, est 8192 at edge N → phase_cfo = 8192 from edge N+2, upd_cnt = 1.
2. IIR smoothing: continuing from (1), est 0 → phase_cfo = 6144. Then est -8192 → 6144 + (-14336 >>> 2) = 2560. upd_cnt = 3.
3. Packet gating: with a 100-beat packet in flight, est 4096 at beat 10 → phase_cfo is unchanged until the tlast beat edge and equals the new value on the next packet's first beat. est_tready stays 0 meanwhile; a second est is held, not dropped.
4. Manual override: cfg_manual_en = 1, cfg_manual_phase = -1000 set mid-packet → phase_cfo = -1000 after tlast. Clearing cfg_manual_en restores acc at the next boundary.
5. run_rx drop: est accepted, run_rx = 0 before the boundary → state IDLE, pending = 0, phase_cfo unchanged, upd_cnt unchanged.
6. Reset mid-PENDING: reset for 1 cycle → phase_cfo = 0, upd_cnt = 0, acc_valid = 0. The next est 300 with alpha = 3 loads directly as phase_cfo = 300.
